// File: rtl/dm_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller:
// width codes, state encoding and byte-lane masks.
package dm_access_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_RD,
        ST_DONE
    } state_t;

    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return MASK_B;
            2'b01:   return MASK_H;
            default: return MASK_W;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        if (we)
            return funct3 inside {F3_B, F3_H, F3_W};
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/dm_load_align.sv
// Extracts and sign/zero-extends a load result from a two-word window.
// Purely combinational so other load paths can reuse it.
module dm_load_align
    import dm_access_ctrl_pkg::*;
(
    input  logic [63:0] data,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [63:0] shifted;

    always_comb begin
        shifted = data >> {off, 3'b000};
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   result = {24'h000000, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   result = {16'h0000, shifted[15:0]};
            default: result = shifted[31:0];
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Initiator side of the data-memory port: turns load/store requests into
// one or two word accesses and returns the extended load result.
module dm_access_ctrl
    import dm_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [3:0]        dm_write,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out
);

    state_t            state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] w0_q;
    logic [1:0]        off_q;
    logic              split_q;
    logic [3:0]        be_hi_q;
    logic [31:0]       sd_hi_q;
    logic [31:0]       lo_q;
    logic [3:0]        dm_write_q;

    logic [7:0]        be64;
    logic [63:0]       sd;
    logic              legal;
    logic [63:0]       align_data;
    logic [31:0]       align_result;

    always_comb begin
        be64       = {4'b0000, size_mask(req_funct3)} << req_addr[1:0];
        sd         = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
        legal      = funct3_legal(req_we, req_funct3);
        align_data = split_q ? {data_out, lo_q} : {32'h0, data_out};
    end

    dm_load_align u_align (
        .data   (align_data),
        .off    (off_q),
        .funct3 (f3_q),
        .result (align_result)
    );

    assign req_ready = (state == ST_IDLE) && !rst;
    // Gating with rst keeps a pending second-half write from reaching memory
    // on the edge that aborts the access.
    assign dm_write  = rst ? '0 : dm_write_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            we_q       <= 1'b0;
            f3_q       <= '0;
            w0_q       <= '0;
            off_q      <= '0;
            split_q    <= 1'b0;
            be_hi_q    <= '0;
            sd_hi_q    <= '0;
            lo_q       <= '0;
            dm_write_q <= '0;
            data_addr  <= '0;
            data_in    <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            dm_write_q <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            case (state)
                ST_IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    f3_q    <= req_funct3;
                    w0_q    <= req_addr[ADDR_W+1:2];
                    off_q   <= req_addr[1:0];
                    split_q <= |be64[7:4];
                    be_hi_q <= be64[7:4];
                    sd_hi_q <= sd[63:32];
                    if (!legal) begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        state      <= ST_ACC0;
                        data_addr  <= req_addr[ADDR_W+1:2];
                        dm_write_q <= req_we ? be64[3:0] : 4'b0000;
                        data_in    <= sd[31:0];
                    end
                end
                ST_ACC0: begin
                    if (split_q) begin
                        state      <= ST_ACC1;
                        data_addr  <= w0_q + 1'b1;
                        dm_write_q <= we_q ? be_hi_q : 4'b0000;
                        data_in    <= sd_hi_q;
                    end else if (!we_q) begin
                        state <= ST_RD;
                    end else begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                ST_ACC1: begin
                    if (!we_q) begin
                        lo_q  <= data_out;
                        state <= ST_RD;
                    end else begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                ST_RD: begin
                    state     <= ST_DONE;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= align_result;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Initiator side of the data-memory port. Converts pipeline load/store requests into datamem accesses.
- A request carries a byte address, funct3 and store data. The block drives the word address, the per-byte write enables `dm_write` and lane-shifted `data_in`.
- For loads it extracts, sign- or zero-extends and returns the result.
- Accesses that straddle a word boundary are split into two consecutive datamem accesses. Sits between the MEM stage and datamem.

Parameters:
- ADDR_W, 10, datamem word-address width (byte address width = ADDR_W+2).
- DATA_W, 32, word width; fixed at 32, with 4 byte lanes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; transfer occurs when req_valid && req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W+2  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load result; 0 for stores.
- rsp_err  out  1  qualifies rsp_valid: illegal funct3.
- dm_write  out  4  datamem byte write enables; bit i writes bits [8i+7:8i].
- data_addr  out  ADDR_W  datamem word address.
- data_in  out  32  datamem write data.
- data_out  in  32  datamem read data; reflects the data_addr sampled at the previous edge (1-cycle read latency).

Behaviour:
- Reset (rst high at an edge):
  - State goes to IDLE.
  - Outputs become: dm_write=0, data_addr=0, data_in=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=0 while rst is high.
- Reset mid-operation:
  - Abandons the access and completes no response.
  - A first-half write already performed stays in memory; the second half is never issued.
- States: IDLE, ACC0, ACC1, RD, DONE.
  - req_ready=1 only in IDLE.
  - dm_write is nonzero only in ACC0/ACC1 with req_we=1; it is 0 in all other states.
- Request latching on accept:
  - Latched values: we, funct3, word address w0=addr[11:2], offset off=addr[1:0], wdata.
  - size mask m: B=0001, H=0011, W=1111.
  - 8-bit be64 = m << off.
  - 64-bit sd = wdata << 8*off.
  - split = |be64[7:4].
- Illegal funct3:
  - For loads: 011, 110, 111. For stores: anything except 000/001/010.
  - Goes IDLE→DONE with rsp_err=1 and no memory access.
- ACC0:
  - data_addr=w0, dm_write=we?be64[3:0]:0, data_in=sd[31:0].
  - Next state: split → ACC1; else load → RD; else → DONE.
- ACC1:
  - data_addr=w0+1, wrapping modulo 2^ADDR_W (0x3FF+1 → 0x000).
  - dm_write=we?be64[7:4]:0, data_in=sd[63:32].
  - For loads, captures data_out as lo word.
  - Next state: load → RD; else → DONE.
- RD:
  - Captures data_out: hi word if split, else lo word.
  - Next state → DONE.
- DONE:
  - rsp_valid=1 for exactly one cycle, then → IDLE.
  - Load result: r = ({hi,lo} >> 8*off).
    - B: sign-extend r[7:0].
    - BU: zero-extend r[7:0].
    - H: sign-extend r[15:0].
    - HU: zero-extend r[15:0].
    - W: r[31:0].
  - For non-split loads, hi is treated as 0.
- Latency from the accept edge to the rsp_valid cycle:
  - aligned store 2 cycles;
  - split store 3;
  - aligned load 3;
  - split load 4;
  - illegal 1.
- Back-to-back: the next request is accepted on the cycle after DONE, i.e. in IDLE. No pipelining.
- Outputs come from registered state only; there are no combinational req→dm paths.

Decomposition:
- Shared package holds:
  - funct3 localparams (F3_B/H/W/BU/HU);
  - state encoding;
  - byte-mask constants.
- One natural sub-module: `dm_load_align`, purely combinational. Takes {hi,lo}, off, funct3 and produces the extended result. It is reused by later loaders.

Test Plan:
- SB, addr 0x001, wdata 0x000000C1 → one ACC cycle with dm_write=0010, data_addr=0x000, data_in=0x0000C100. rsp_valid 2 cycles after accept; mem[0] byte1 = C1, others unchanged.
- mem[0]=0x8899AABB, mem[1]=0x11223344:
  - LB addr 0x003 → rsp_rdata=0xFFFFFF88;
  - LBU addr 0x003 → 0x00000088;
  - LW addr 0x000 → 0x8899AABB after 3 cycles.
- Split loads, same memory contents:
  - LH addr 0x003 → data_addr 0x000 then 0x001, dm_write stays 0, rsp_rdata=0x00004488 after 4 cycles;
  - LW addr 0x002 → 0x33448899.
- Split store with wrap: SW addr 0xFFD, wdata 0xA1B2C3D4.
  - Cycle 1: data_addr=0x3FF, dm_write=1110, data_in=0xB2C3D400.
  - Cycle 2: data_addr=0x000, dm_write=0001, data_in=0x000000A1.
  - Memory read-back matches.
- Illegal funct3 011 load → no dm_write, data_addr unchanged, rsp_valid and rsp_err high 1 cycle after accept. Next request is accepted the following cycle.
- rst asserted during ACC1 of the SW above → next cycle state IDLE, dm_write=0, no rsp_valid. Word 0x3FF holds the first-half bytes; word 0x000 is unchanged.
